// File: rtl/onchip_arb_pkg.sv
// Shared defaults and types for the two-master on-chip RAM arbiter.
package onchip_arb_pkg;

  localparam int unsigned ARB_ADDR_W    = 15;
  localparam int unsigned ARB_DATA_W    = 32;
  localparam int unsigned ARB_BE_W      = ARB_DATA_W / 8;
  localparam int unsigned ARB_NUM_WORDS = 20480;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } port_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer updated only on a real grant.
module rr_arb2
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_idx_e last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) begin
        // Tie goes to whichever master did not win the previous grant.
        gnt = (last_q == M1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0]) begin
      last_d = M0;
    end else if (gnt[1]) begin
      last_d = M1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin grants,
// out-of-range blocking and per-master read response steering.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned BE_W      = ARB_BE_W,
  parameter int unsigned NUM_WORDS = ARB_NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,

  input  logic              err_clr,
  output logic [1:0]        oor_err
);

  logic [1:0] req, oor, gnt, oor_set;
  logic       any_gnt, sel_oor, sel_rd, sel_wr, rd_acc;
  port_idx_e  sel;

  logic       rsp_valid_q;
  port_idx_e  rsp_owner_q;
  logic       rsp_oor_q;
  logic [1:0] oor_err_q, oor_err_d;

  assign req    = {m1_read | m1_write, m0_read | m0_write};
  assign oor[0] = 32'(m0_address) >= NUM_WORDS;
  assign oor[1] = 32'(m1_address) >= NUM_WORDS;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (~reset_req & ~reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign any_gnt = |gnt;
  assign sel     = gnt[1] ? M1 : M0;

  // With no grant the m0 side drives the RAM bus; chipselect keeps it inert.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    sel_oor        = oor[0];
    sel_rd         = m0_read;
    sel_wr         = m0_write;
    if (sel == M1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      sel_oor        = oor[1];
      sel_rd         = m1_read;
      sel_wr         = m1_write;
    end
  end

  assign mem_chipselect = any_gnt & ~sel_oor;
  assign mem_write      = mem_chipselect & sel_wr;
  assign mem_clken      = 1'b1;

  // Read+write together is treated as a write, so it gets no response.
  assign rd_acc  = any_gnt & sel_rd & ~sel_wr;
  assign oor_set = gnt & oor;

  assign m0_waitrequest = req[0] & ~gnt[0];
  assign m1_waitrequest = req[1] & ~gnt[1];

  always_comb begin
    oor_err_d = err_clr ? 2'b00 : oor_err_q;
    oor_err_d = oor_err_d | oor_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= M0;
      rsp_oor_q   <= 1'b0;
      oor_err_q   <= 2'b00;
    end else begin
      rsp_valid_q <= rd_acc;
      if (rd_acc) begin
        rsp_owner_q <= sel;
        rsp_oor_q   <= sel_oor;
      end
      oor_err_q <= oor_err_d;
    end
  end

  assign oor_err = oor_err_q;

  // Data is broadcast; only the valid strobe is steered. Masking with reset drops
  // a response whose read was accepted just before reset asserted.
  assign m0_readdata      = rsp_oor_q ? '0 : mem_readdata;
  assign m1_readdata      = rsp_oor_q ? '0 : mem_readdata;
  assign m0_readdatavalid = rsp_valid_q & (rsp_owner_q == M0) & ~reset;
  assign m1_readdatavalid = rsp_valid_q & (rsp_owner_q == M1) & ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a RAM model and a read-response scoreboard.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_req, err_clr;
  logic [14:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [1:0]  oor_err;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .reset_req        (reset_req),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .err_clr          (err_clr),
    .oor_err          (oor_err)
  );

  // RAM model: registered address, unregistered q, byte-lane writes.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_rd(input logic owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    e.due   = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: a due entry must appear on exactly its owner's port; any other valid is spurious.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.owner) begin
        check("rsp_m1_valid", {31'd0, m1_readdatavalid}, 32'd1);
        check("rsp_m0_quiet", {31'd0, m0_readdatavalid}, 32'd0);
        check("rsp_m1_data", m1_readdata, e.data);
      end else begin
        check("rsp_m0_valid", {31'd0, m0_readdatavalid}, 32'd1);
        check("rsp_m1_quiet", {31'd0, m1_readdatavalid}, 32'd0);
        check("rsp_m0_data", m0_readdata, e.data);
      end
    end else if (m0_readdatavalid || m1_readdatavalid) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_rsp: got valid m0=%0b m1=%0b, expected none (cycle %0d)",
               m0_readdatavalid, m1_readdatavalid, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; err_clr = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; reset_req = 0; err_clr = 0;
    m0_address = 0; m1_address = 0; m0_writedata = 0; m1_writedata = 0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;

    // Reset: requests are held off, nothing forwarded.
    tick(); m0_read = 1; m0_address = 15'h10;
    @(negedge clk);
    check("rst_wait_m0", {31'd0, m0_waitrequest}, 32'd1);
    check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
    check("rst_oor", {30'd0, oor_err}, 32'd0);
    check("clken", {31'd0, mem_clken}, 32'd1);
    tick(); reset = 0;

    // Write then read back on m0.
    tick(); m0_write = 1; m0_address = 15'h10; m0_writedata = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_wait", {31'd0, m0_waitrequest}, 32'd0);
    check("wr_cs", {31'd0, mem_chipselect}, 32'd1);
    check("wr_we", {31'd0, mem_write}, 32'd1);
    tick(); m0_read = 1; m0_address = 15'h10; expect_rd(0, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_wait", {31'd0, m0_waitrequest}, 32'd0);
    check("rd_m1_wait_idle", {31'd0, m1_waitrequest}, 32'd0);
    check("rd_we", {31'd0, mem_write}, 32'd0);

    // Preload, ending on an m1 grant so m0 wins the next tie.
    tick(); m0_write = 1; m0_address = 15'h1; m0_writedata = 32'h11111111;
    tick(); m1_write = 1; m1_address = 15'h2; m1_writedata = 32'h22222222;
    @(negedge clk);
    check("m1_wr_addr", {17'd0, mem_address}, 32'h2);

    // Both masters read continuously: grants alternate m0, m1, ...
    for (int k = 0; k < 8; k++) begin
      tick();
      m0_read = 1; m0_address = 15'h1; m1_read = 1; m1_address = 15'h2;
      if (k % 2 == 0) expect_rd(0, 32'h11111111);
      else            expect_rd(1, 32'h22222222);
      @(negedge clk);
      check("alt_wait_m0", {31'd0, m0_waitrequest}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check("alt_wait_m1", {31'd0, m1_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Partial byte-enable write from m1 over all-ones.
    tick(); m0_write = 1; m0_address = 15'h20; m0_writedata = 32'hFFFFFFFF;
    tick(); m1_write = 1; m1_address = 15'h20; m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
    @(negedge clk);
    check("be_lanes", {28'd0, mem_byteenable}, 32'h3);
    tick(); m0_read = 1; m0_address = 15'h20; expect_rd(0, 32'hFFFF5678);

    // Out-of-range read on m1: accepted, not forwarded, returns zero.
    tick(); m1_read = 1; m1_address = 15'd20480; expect_rd(1, 32'h0);
    @(negedge clk);
    check("oor_wait", {31'd0, m1_waitrequest}, 32'd0);
    check("oor_cs", {31'd0, mem_chipselect}, 32'd0);
    tick(); err_clr = 1;
    @(negedge clk);
    check("oor_flag_m1", {30'd0, oor_err}, 32'h2);
    tick();
    @(negedge clk);
    check("oor_cleared", {30'd0, oor_err}, 32'h0);
    // Out-of-range write with err_clr in the same cycle: the set wins.
    tick(); m0_write = 1; m0_address = 15'd20481; m0_writedata = 32'hA5A5A5A5; err_clr = 1;
    @(negedge clk);
    check("oorw_cs", {31'd0, mem_chipselect}, 32'd0);
    check("oorw_wait", {31'd0, m0_waitrequest}, 32'd0);
    tick();
    @(negedge clk);
    check("oor_set_wins", {30'd0, oor_err}, 32'h1);
    tick(); err_clr = 1;

    // reset_req: pending response still delivered, new requests stall.
    tick(); m0_read = 1; m0_address = 15'h10; expect_rd(0, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      tick(); reset_req = 1; m1_read = 1; m1_address = 15'h2;
      @(negedge clk);
      check("rreq_wait_m1", {31'd0, m1_waitrequest}, 32'd1);
      check("rreq_cs", {31'd0, mem_chipselect}, 32'd0);
    end
    tick(); reset_req = 0; m1_read = 1; m1_address = 15'h2; expect_rd(1, 32'h22222222);
    @(negedge clk);
    check("rreq_release", {31'd0, m1_waitrequest}, 32'd0);

    // Read accepted, then reset: response dropped; first tie afterwards goes to m0.
    tick(); m0_read = 1; m0_address = 15'h1;
    tick(); reset = 1;
    tick(); reset = 1;
    tick(); reset = 0;
    m0_read = 1; m0_address = 15'h1; m1_read = 1; m1_address = 15'h2;
    expect_rd(0, 32'h11111111);
    @(negedge clk);
    check("post_rst_m0", {31'd0, m0_waitrequest}, 32'd0);
    check("post_rst_m1", {31'd0, m1_waitrequest}, 32'd1);
    tick(); m1_read = 1; m1_address = 15'h2; expect_rd(1, 32'h22222222);

    tick(); tick(); tick();
    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
